latch_bank_writer: RTL and testbench



---
 rtl/latch_bank_writer_if.sv | 12 +
 rtl/latch_bank_writer.sv | 139 +++++++++++++
 tb/tb_latch_bank_writer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/latch_bank_writer_if.sv
// Command stream into latch_bank_writer: valid/ready handshake carrying a write mask and data.
interface latch_bank_writer_if #(
  parameter int WIDTH = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_mask;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_mask, output cmd_data, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_mask, input  cmd_data, output cmd_ready);
endinterface

// File: rtl/latch_bank_writer.sv
// Sequences masked writes into a level-sensitive latch bank with registered setup/pulse/hold phases.
// Optional LATCH_WR_SHADOW_EN adds a shadow copy of the last value written to each latch bit.
module latch_bank_writer #(
  parameter int WIDTH     = 3,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  latch_bank_writer_if.slave cmd,
  output logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_en,
  output logic              busy,
`ifdef LATCH_WR_SHADOW_EN
  output logic [WIDTH-1:0]  shadow,
`endif
  output logic              done
);
  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_C  = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW     = $clog2(MAX_C + 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t PULSE_LD = cnt_t'(PULSE_CYC - 1);
  localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t           state, state_nxt;
  cnt_t             cnt, cnt_nxt;
  logic [WIDTH-1:0] mask_q, mask_nxt;
  logic [WIDTH-1:0] din_nxt, den_nxt;
  logic             busy_nxt, done_nxt;
  logic             ready_q, ready_nxt;
  logic             accept;
`ifdef LATCH_WR_SHADOW_EN
  logic [WIDTH-1:0] shadow_nxt;
`endif

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid & ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mask_q  <= '0;
      d_in    <= '0;
      d_en    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready_q <= 1'b0;
`ifdef LATCH_WR_SHADOW_EN
      shadow  <= '0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mask_q  <= mask_nxt;
      d_in    <= din_nxt;
      d_en    <= den_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      ready_q <= ready_nxt;
`ifdef LATCH_WR_SHADOW_EN
      shadow  <= shadow_nxt;
`endif
    end
  end

  // Every output is computed one cycle ahead so the flops drive the pins directly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mask_nxt  = mask_q;
    din_nxt   = d_in;
    den_nxt   = d_en;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    ready_nxt = ready_q;
`ifdef LATCH_WR_SHADOW_EN
    shadow_nxt = shadow;
`endif
    unique case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        den_nxt   = '0;
        if (accept) begin
          if (|cmd.cmd_mask) begin
            mask_nxt  = cmd.cmd_mask;
            din_nxt   = (d_in & ~cmd.cmd_mask) | (cmd.cmd_data & cmd.cmd_mask);
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
            ready_nxt = 1'b0;
            busy_nxt  = 1'b1;
          end else begin
            // Nothing to write: acknowledge without opening any enable.
            done_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LD;
          den_nxt   = mask_q;
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
          den_nxt   = '0;
`ifdef LATCH_WR_SHADOW_EN
          shadow_nxt = (shadow & ~mask_q) | (d_in & mask_q);
`endif
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_latch_bank_writer.sv
// Directed-vector bench for latch_bank_writer at default parameters (setup 1, pulse 2, hold 1).
module tb_latch_bank_writer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] d_in, d_en;
  logic       busy, done;
`ifdef LATCH_WR_SHADOW_EN
  logic [2:0] shadow;
`endif
  int n_vec = 0;
  int n_err = 0;

  latch_bank_writer_if #(.WIDTH(3)) cmd_if ();

  latch_bank_writer #(.WIDTH(3), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd     (cmd_if),
    .d_in    (d_in),
    .d_en    (d_en),
    .busy    (busy),
`ifdef LATCH_WR_SHADOW_EN
    .shadow  (shadow),
`endif
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in cycle 1 after the accepting edge; checks cycles 1..5 and returns in cycle 5.
  task automatic watch_cmd(input string tag, input logic [2:0] mask, input logic [2:0] din);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("%s c%0d d_en", tag, c), d_en, (c == 2 || c == 3) ? mask : 3'b000);
      chk($sformatf("%s c%0d d_in", tag, c), d_in, din);
      chk($sformatf("%s c%0d busy", tag, c), busy, (c < 5) ? 1 : 0);
      chk($sformatf("%s c%0d done", tag, c), done, (c == 5) ? 1 : 0);
      chk($sformatf("%s c%0d ready", tag, c), cmd_if.cmd_ready, (c == 5) ? 1 : 0);
      if (c < 5) step();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mask  = 3'b000;
    cmd_if.cmd_data  = 3'b000;
    step(); step();
    chk("rst d_in", d_in, 0);
    chk("rst d_en", d_en, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst ready", cmd_if.cmd_ready, 0);
`ifdef LATCH_WR_SHADOW_EN
    chk("rst shadow", shadow, 0);
`endif
    reset_n = 1'b1;
    chk("post-release ready", cmd_if.cmd_ready, 0);
    step();
    chk("ready after release", cmd_if.cmd_ready, 1);

    // single write: mask 101 data 111
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mask = 3'b101; cmd_if.cmd_data = 3'b111;
    step();
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_mask = 3'b111; cmd_if.cmd_data = 3'b000;
    watch_cmd("single", 3'b101, 3'b101);
`ifdef LATCH_WR_SHADOW_EN
    chk("single shadow", shadow, 3'b101);
`endif
    step();
    chk("single done drop", done, 0);

    // partial update: only bit 1 moves
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mask = 3'b010; cmd_if.cmd_data = 3'b010;
    step();
    cmd_if.cmd_valid = 1'b0;
    watch_cmd("partial", 3'b010, 3'b111);
`ifdef LATCH_WR_SHADOW_EN
    chk("partial shadow", shadow, 3'b111);
`endif
    step();

    // back-to-back with valid held: second command accepted on edge 5
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mask = 3'b111; cmd_if.cmd_data = 3'b000;
    step();
    cmd_if.cmd_mask = 3'b001; cmd_if.cmd_data = 3'b001;
    watch_cmd("b2b1", 3'b111, 3'b000);
    step();
    cmd_if.cmd_valid = 1'b0;
    chk("b2b2 done clr", done, 0);
    watch_cmd("b2b2", 3'b001, 3'b001);
`ifdef LATCH_WR_SHADOW_EN
    chk("b2b shadow", shadow, 3'b001);
`endif
    step();

    // zero mask: done next cycle, nothing else moves
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mask = 3'b000; cmd_if.cmd_data = 3'b111;
    step();
    cmd_if.cmd_valid = 1'b0;
    chk("zero done", done, 1);
    chk("zero busy", busy, 0);
    chk("zero ready", cmd_if.cmd_ready, 1);
    chk("zero d_en", d_en, 0);
    chk("zero d_in", d_in, 3'b001);
    step();
    chk("zero done drop", done, 0);
    chk("zero d_in hold", d_in, 3'b001);

    // reset during PULSE
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mask = 3'b110; cmd_if.cmd_data = 3'b110;
    step();
    cmd_if.cmd_valid = 1'b0;
    chk("rp c1 d_in", d_in, 3'b111);
    step();
    chk("rp c2 d_en", d_en, 3'b110);
    #2 reset_n = 1'b0;
    #1;
    chk("rp async d_en", d_en, 0);
    chk("rp async d_in", d_in, 0);
    chk("rp async busy", busy, 0);
    chk("rp async ready", cmd_if.cmd_ready, 0);
    step(); step();
    chk("rp no done", done, 0);
`ifdef LATCH_WR_SHADOW_EN
    chk("rp shadow", shadow, 0);
`endif
    reset_n = 1'b1;
    step();
    chk("rp ready", cmd_if.cmd_ready, 1);
    chk("rp done idle", done, 0);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mask = 3'b011; cmd_if.cmd_data = 3'b010;
    step();
    cmd_if.cmd_valid = 1'b0;
    watch_cmd("after rst", 3'b011, 3'b010);
`ifdef LATCH_WR_SHADOW_EN
    chk("after rst shadow", shadow, 3'b010);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
